// File: rtl/atm_core_param_if.sv
// Request/response bundle between the menu logic and the ATM transaction engine.
interface atm_core_param_if #(
  parameter int unsigned ACC_W = 3,
  parameter int unsigned PIN_W = 16,
  parameter int unsigned BAL_W = 16
) ();
  logic             start;
  logic [2:0]       operation;
  logic [ACC_W-1:0] acc_num;
  logic [ACC_W-1:0] dst_acc;
  logic [PIN_W-1:0] pin;
  logic [PIN_W-1:0] new_pin;
  logic [BAL_W-1:0] amount;
  logic             language;
  logic             busy;
  logic             done;
  logic             success;
  logic [2:0]       err_code;
  logic [BAL_W-1:0] balance;
  logic             lang_out;

  modport master (
    output start, operation, acc_num, dst_acc, pin, new_pin, amount, language,
    input  busy, done, success, err_code, balance, lang_out
  );

  modport slave (
    input  start, operation, acc_num, dst_acc, pin, new_pin, amount, language,
    output busy, done, success, err_code, balance, lang_out
  );
endinterface

// File: rtl/atm_core_param.sv
// ATM transaction engine: account/PIN tables, wrong-PIN lockout, transfers, error codes.
module atm_core_param #(
  parameter int unsigned NUM_ACC   = 8,
  parameter int unsigned ACC_W     = 3,
  parameter int unsigned PIN_W     = 16,
  parameter int unsigned BAL_W     = 16,
  parameter int unsigned INIT_BAL  = 1000,
  parameter int unsigned INIT_PIN  = 'h1234,
  parameter int unsigned MAX_TRIES = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  atm_core_param_if.slave bus
);

  localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
  localparam logic [ACC_W:0] NUM_ACC_X = (ACC_W+1)'(NUM_ACC);

  localparam logic [2:0] OP_BAL = 3'd0;
  localparam logic [2:0] OP_WD  = 3'd1;
  localparam logic [2:0] OP_DEP = 3'd2;
  localparam logic [2:0] OP_PIN = 3'd3;
  localparam logic [2:0] OP_XFR = 3'd4;

  localparam logic [2:0] ERR_OK     = 3'd0;
  localparam logic [2:0] ERR_ACC    = 3'd1;
  localparam logic [2:0] ERR_PIN    = 3'd2;
  localparam logic [2:0] ERR_LOCK   = 3'd3;
  localparam logic [2:0] ERR_FUNDS  = 3'd4;
  localparam logic [2:0] ERR_OVF    = 3'd5;
  localparam logic [2:0] ERR_ILLEGAL = 3'd6;

  typedef enum logic [1:0] {IDLE, AUTH, EXEC, RESP} state_t;

  state_t state_q, state_d;

  logic [BAL_W-1:0] bal_q  [NUM_ACC];
  logic [PIN_W-1:0] pin_q  [NUM_ACC];
  logic [TRY_W-1:0] fail_q [NUM_ACC];
  logic             lock_q [NUM_ACC];

  logic [2:0]       op_q;
  logic [ACC_W-1:0] acc_q, dst_q;
  logic [PIN_W-1:0] pin_in_q, new_pin_q;
  logic [BAL_W-1:0] amt_q;
  logic             lang_q;
  logic [2:0]       err_q;

  logic             acc_ok, dst_in, dst_ok, src_lock, pin_bad;
  logic [BAL_W-1:0] src_bal, dst_bal;
  logic [PIN_W-1:0] src_pin;
  logic [TRY_W-1:0] src_fail, fail_nxt;
  logic [BAL_W:0]   src_sum, dst_sum;
  logic [2:0]       auth_err, exec_err;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: fixed four-step walk once a request is accepted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = AUTH;
      AUTH:    state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Table lookups and the authorisation/execution verdicts for the latched request.
  always_comb begin
    acc_ok   = ({1'b0, acc_q} < NUM_ACC_X);
    dst_in   = ({1'b0, dst_q} < NUM_ACC_X);
    dst_ok   = dst_in && (dst_q != acc_q);
    src_bal  = '0;
    src_pin  = '0;
    src_fail = '0;
    src_lock = 1'b0;
    dst_bal  = '0;
    if (acc_ok) begin
      src_bal  = bal_q[acc_q];
      src_pin  = pin_q[acc_q];
      src_fail = fail_q[acc_q];
      src_lock = lock_q[acc_q];
    end
    if (dst_in) dst_bal = bal_q[dst_q];
    pin_bad  = (pin_in_q != src_pin);
    fail_nxt = src_fail + TRY_W'(1);
    src_sum  = {1'b0, src_bal} + {1'b0, amt_q};
    dst_sum  = {1'b0, dst_bal} + {1'b0, amt_q};

    auth_err = ERR_OK;
    if (!acc_ok)       auth_err = ERR_ACC;
    else if (src_lock) auth_err = ERR_LOCK;
    else if (pin_bad)  auth_err = ERR_PIN;

    exec_err = ERR_OK;
    case (op_q)
      OP_BAL, OP_PIN: exec_err = ERR_OK;
      OP_WD:          if (amt_q > src_bal) exec_err = ERR_FUNDS;
      OP_DEP:         if (src_sum[BAL_W]) exec_err = ERR_OVF;
      OP_XFR: begin
        if (!dst_ok)               exec_err = ERR_ACC;
        else if (amt_q > src_bal)  exec_err = ERR_FUNDS;
        else if (dst_sum[BAL_W])   exec_err = ERR_OVF;
      end
      default:        exec_err = ERR_ILLEGAL;
    endcase
  end

  // Request latch, PIN-retry bookkeeping and account table updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_ACC; i++) begin
        bal_q[i]  <= BAL_W'(INIT_BAL);
        pin_q[i]  <= PIN_W'(INIT_PIN);
        fail_q[i] <= '0;
        lock_q[i] <= 1'b0;
      end
      op_q      <= '0;
      acc_q     <= '0;
      dst_q     <= '0;
      pin_in_q  <= '0;
      new_pin_q <= '0;
      amt_q     <= '0;
      lang_q    <= 1'b0;
      err_q     <= ERR_OK;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          op_q      <= bus.operation;
          acc_q     <= bus.acc_num;
          dst_q     <= bus.dst_acc;
          pin_in_q  <= bus.pin;
          new_pin_q <= bus.new_pin;
          amt_q     <= bus.amount;
          lang_q    <= bus.language;
        end
        AUTH: begin
          err_q <= auth_err;
          if (acc_ok && !src_lock) begin
            if (pin_bad) begin
              fail_q[acc_q] <= fail_nxt;
              if (fail_nxt == TRY_W'(MAX_TRIES)) lock_q[acc_q] <= 1'b1;
            end else begin
              fail_q[acc_q] <= '0;
            end
          end
        end
        EXEC: if (err_q == ERR_OK) begin
          err_q <= exec_err;
          if (exec_err == ERR_OK) begin
            case (op_q)
              OP_WD:  bal_q[acc_q] <= src_bal - amt_q;
              OP_DEP: bal_q[acc_q] <= src_sum[BAL_W-1:0];
              OP_PIN: pin_q[acc_q] <= new_pin_q;
              OP_XFR: begin
                bal_q[acc_q] <= src_bal - amt_q;
                bal_q[dst_q] <= dst_sum[BAL_W-1:0];
              end
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  // Registered status: busy tracks the walk, results publish on the edge leaving RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.success  <= 1'b0;
      bus.err_code <= ERR_OK;
      bus.balance  <= '0;
      bus.lang_out <= 1'b0;
    end else begin
      bus.busy <= (state_d != IDLE);
      bus.done <= (state_q == RESP);
      if (state_q == RESP) begin
        bus.success  <= (err_q == ERR_OK);
        bus.err_code <= err_q;
        bus.balance  <= src_bal;
        bus.lang_out <= lang_q;
      end
    end
  end

endmodule

// File: tb/tb_atm_core_param.sv
// Directed bench for atm_core_param: default instance plus a NUM_ACC=6 instance.
module tb_atm_core_param;

  localparam int unsigned ACC_W = 3;
  localparam int unsigned PIN_W = 16;
  localparam int unsigned BAL_W = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  atm_core_param_if #(.ACC_W(ACC_W), .PIN_W(PIN_W), .BAL_W(BAL_W)) bus0 ();
  atm_core_param_if #(.ACC_W(ACC_W), .PIN_W(PIN_W), .BAL_W(BAL_W)) bus1 ();

  atm_core_param #(.NUM_ACC(8), .ACC_W(ACC_W), .PIN_W(PIN_W), .BAL_W(BAL_W)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  atm_core_param #(.NUM_ACC(6), .ACC_W(ACC_W), .PIN_W(PIN_W), .BAL_W(BAL_W)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  int checks   = 0;
  int failures = 0;

  logic             r_success;
  logic [2:0]       r_err;
  logic [BAL_W-1:0] r_bal;
  logic             r_lang;
  int               r_lat;
  int               r_busy;

  // Drive the shared request fields of both instances.
  task automatic set_req(input logic [2:0] op, input logic [ACC_W-1:0] acc, input logic [ACC_W-1:0] dst,
                         input logic [PIN_W-1:0] p, input logic [PIN_W-1:0] np,
                         input logic [BAL_W-1:0] amt, input logic lang);
    bus0.operation = op;  bus1.operation = op;
    bus0.acc_num = acc;   bus1.acc_num = acc;
    bus0.dst_acc = dst;   bus1.dst_acc = dst;
    bus0.pin = p;         bus1.pin = p;
    bus0.new_pin = np;    bus1.new_pin = np;
    bus0.amount = amt;    bus1.amount = amt;
    bus0.language = lang; bus1.language = lang;
  endtask

  // One transaction on the selected instance; entered and left on a falling edge.
  task automatic do_txn(input bit sel, input logic [2:0] op, input logic [ACC_W-1:0] acc,
                        input logic [ACC_W-1:0] dst, input logic [PIN_W-1:0] p,
                        input logic [PIN_W-1:0] np, input logic [BAL_W-1:0] amt, input logic lang);
    set_req(op, acc, dst, p, np, amt, lang);
    if (sel) bus1.start = 1'b1; else bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    set_req(3'd7, '1, '1, '0, '0, '1, ~lang);
    r_lat  = 0;
    r_busy = 0;
    while (!(sel ? bus1.done : bus0.done) && r_lat < 12) begin
      if (sel ? bus1.busy : bus0.busy) r_busy++;
      @(negedge clk);
      r_lat++;
    end
    r_success = sel ? bus1.success  : bus0.success;
    r_err     = sel ? bus1.err_code : bus0.err_code;
    r_bal     = sel ? bus1.balance  : bus0.balance;
    r_lang    = sel ? bus1.lang_out : bus0.lang_out;
  endtask

  task automatic test_reset();
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    set_req('0, '0, '0, '0, '0, '0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus0.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", bus0.busy); end
    checks++; if (bus0.done !== 1'b0) begin failures++; $display("FAIL rst_done got=%0b exp=0", bus0.done); end
    checks++; if ({bus0.success, bus0.err_code, bus0.lang_out} !== 5'b0) begin failures++;
      $display("FAIL rst_status got=%0b/%0d/%0b exp=0/0/0", bus0.success, bus0.err_code, bus0.lang_out); end
    checks++; if (bus0.balance !== 16'd0) begin failures++; $display("FAIL rst_balance got=%0d exp=0", bus0.balance); end
  endtask

  task automatic test_inquiry();
    do_txn(1'b0, 3'd0, 3'd2, 3'd0, 16'h1234, 16'h0, 16'd0, 1'b1);
    checks++; if (r_lat !== 3) begin failures++; $display("FAIL inq_latency got=%0d exp=3", r_lat); end
    checks++; if (r_busy !== 3) begin failures++; $display("FAIL inq_busy_cycles got=%0d exp=3", r_busy); end
    checks++; if (r_success !== 1'b1 || r_err !== 3'd0) begin failures++; $display("FAIL inq_status got=%0b/%0d exp=1/0", r_success, r_err); end
    checks++; if (r_bal !== 16'd1000) begin failures++; $display("FAIL inq_balance got=%0d exp=1000", r_bal); end
    checks++; if (r_lang !== 1'b1) begin failures++; $display("FAIL inq_lang got=%0b exp=1", r_lang); end
  endtask

  task automatic test_withdraw();
    do_txn(1'b0, 3'd1, 3'd1, 3'd0, 16'h1234, 16'h0, 16'd300, 1'b0);
    checks++; if (r_success !== 1'b1 || r_bal !== 16'd700) begin failures++; $display("FAIL wd300 got=%0b/%0d exp=1/700", r_success, r_bal); end
    do_txn(1'b0, 3'd1, 3'd1, 3'd0, 16'h1234, 16'h0, 16'd701, 1'b0);
    checks++; if (r_success !== 1'b0 || r_err !== 3'd4) begin failures++; $display("FAIL wd701_err got=%0b/%0d exp=0/4", r_success, r_err); end
    checks++; if (r_bal !== 16'd700) begin failures++; $display("FAIL wd701_balance got=%0d exp=700", r_bal); end
    do_txn(1'b0, 3'd1, 3'd1, 3'd0, 16'h1234, 16'h0, 16'd700, 1'b0);
    checks++; if (r_err !== 3'd0 || r_bal !== 16'd0) begin failures++; $display("FAIL wd700 got=%0d/%0d exp=0/0", r_err, r_bal); end
  endtask

  task automatic test_deposit();
    do_txn(1'b0, 3'd2, 3'd3, 3'd0, 16'h1234, 16'h0, 16'd65000, 1'b0);
    checks++; if (r_err !== 3'd5 || r_bal !== 16'd1000) begin failures++; $display("FAIL dep_ovf got=%0d/%0d exp=5/1000", r_err, r_bal); end
    do_txn(1'b0, 3'd2, 3'd3, 3'd0, 16'h1234, 16'h0, 16'd0, 1'b0);
    checks++; if (r_success !== 1'b1 || r_bal !== 16'd1000) begin failures++; $display("FAIL dep_zero got=%0b/%0d exp=1/1000", r_success, r_bal); end
  endtask

  task automatic test_lockout();
    for (int i = 0; i < 3; i++) begin
      do_txn(1'b0, 3'd0, 3'd4, 3'd0, 16'h0000, 16'h0, 16'd0, 1'b0);
      checks++; if (r_err !== 3'd2) begin failures++; $display("FAIL lock_wrong%0d got=%0d exp=2", i, r_err); end
    end
    do_txn(1'b0, 3'd0, 3'd4, 3'd0, 16'h1234, 16'h0, 16'd0, 1'b0);
    checks++; if (r_err !== 3'd3 || r_success !== 1'b0) begin failures++; $display("FAIL lock_locked got=%0d/%0b exp=3/0", r_err, r_success); end
    do_txn(1'b0, 3'd0, 3'd5, 3'd0, 16'h1234, 16'h0, 16'd0, 1'b0);
    checks++; if (r_err !== 3'd0 || r_bal !== 16'd1000) begin failures++; $display("FAIL lock_neighbour got=%0d/%0d exp=0/1000", r_err, r_bal); end
  endtask

  task automatic test_transfer();
    do_txn(1'b0, 3'd4, 3'd0, 3'd6, 16'h1234, 16'h0, 16'd400, 1'b0);
    checks++; if (r_success !== 1'b1 || r_bal !== 16'd600) begin failures++; $display("FAIL xfr400 got=%0b/%0d exp=1/600", r_success, r_bal); end
    do_txn(1'b0, 3'd0, 3'd6, 3'd0, 16'h1234, 16'h0, 16'd0, 1'b0);
    checks++; if (r_bal !== 16'd1400) begin failures++; $display("FAIL xfr_dst_balance got=%0d exp=1400", r_bal); end
    do_txn(1'b0, 3'd4, 3'd0, 3'd0, 16'h1234, 16'h0, 16'd10, 1'b0);
    checks++; if (r_err !== 3'd1 || r_bal !== 16'd600) begin failures++; $display("FAIL xfr_self got=%0d/%0d exp=1/600", r_err, r_bal); end
    do_txn(1'b0, 3'd4, 3'd0, 3'd6, 16'h1234, 16'h0, 16'd601, 1'b0);
    checks++; if (r_err !== 3'd4 || r_bal !== 16'd600) begin failures++; $display("FAIL xfr_funds got=%0d/%0d exp=4/600", r_err, r_bal); end
    do_txn(1'b0, 3'd2, 3'd2, 3'd0, 16'h1234, 16'h0, 16'd64000, 1'b0);
    checks++; if (r_bal !== 16'd65000) begin failures++; $display("FAIL dep64000 got=%0d exp=65000", r_bal); end
    do_txn(1'b0, 3'd4, 3'd6, 3'd2, 16'h1234, 16'h0, 16'd600, 1'b0);
    checks++; if (r_err !== 3'd5 || r_bal !== 16'd1400) begin failures++; $display("FAIL xfr_dst_ovf got=%0d/%0d exp=5/1400", r_err, r_bal); end
    do_txn(1'b0, 3'd0, 3'd2, 3'd0, 16'h1234, 16'h0, 16'd0, 1'b0);
    checks++; if (r_bal !== 16'd65000) begin failures++; $display("FAIL xfr_ovf_untouched got=%0d exp=65000", r_bal); end
    do_txn(1'b0, 3'd4, 3'd0, 3'd6, 16'h1234, 16'h0, 16'd0, 1'b0);
    checks++; if (r_success !== 1'b1 || r_bal !== 16'd600) begin failures++; $display("FAIL xfr_zero got=%0b/%0d exp=1/600", r_success, r_bal); end
  endtask

  task automatic test_illegal_op();
    do_txn(1'b0, 3'd5, 3'd2, 3'd0, 16'h1234, 16'h0, 16'd5, 1'b0);
    checks++; if (r_err !== 3'd6 || r_bal !== 16'd65000) begin failures++; $display("FAIL illegal_op got=%0d/%0d exp=6/65000", r_err, r_bal); end
  endtask

  task automatic test_pin_change();
    do_txn(1'b0, 3'd3, 3'd7, 3'd0, 16'h1234, 16'hBEEF, 16'd0, 1'b0);
    checks++; if (r_success !== 1'b1) begin failures++; $display("FAIL pin_change got=%0b exp=1", r_success); end
    do_txn(1'b0, 3'd0, 3'd7, 3'd0, 16'h1234, 16'h0, 16'd0, 1'b0);
    checks++; if (r_err !== 3'd2) begin failures++; $display("FAIL pin_old got=%0d exp=2", r_err); end
    do_txn(1'b0, 3'd0, 3'd7, 3'd0, 16'hBEEF, 16'h0, 16'd0, 1'b0);
    checks++; if (r_err !== 3'd0 || r_bal !== 16'd1000) begin failures++; $display("FAIL pin_new got=%0d/%0d exp=0/1000", r_err, r_bal); end
  endtask

  task automatic test_back_to_back();
    do_txn(1'b0, 3'd1, 3'd5, 3'd0, 16'h1234, 16'h0, 16'd1, 1'b0);
    do_txn(1'b0, 3'd1, 3'd5, 3'd0, 16'h1234, 16'h0, 16'd1, 1'b0);
    checks++; if (r_lat !== 3 || r_bal !== 16'd998) begin failures++; $display("FAIL b2b got=lat%0d/%0d exp=lat3/998", r_lat, r_bal); end
  endtask

  task automatic test_busy_ignore();
    int n_done;
    set_req(3'd0, 3'd5, 3'd0, 16'h1234, 16'h0, 16'd0, 1'b0);
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    @(negedge clk);
    set_req(3'd1, 3'd5, 3'd0, 16'h1234, 16'h0, 16'd100, 1'b0);
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    n_done = 0;
    repeat (8) begin
      if (bus0.done) n_done++;
      @(negedge clk);
    end
    checks++; if (n_done !== 1) begin failures++; $display("FAIL busy_ignore_dones got=%0d exp=1", n_done); end
    do_txn(1'b0, 3'd0, 3'd5, 3'd0, 16'h1234, 16'h0, 16'd0, 1'b0);
    checks++; if (r_bal !== 16'd998) begin failures++; $display("FAIL busy_ignore_balance got=%0d exp=998", r_bal); end
  endtask

  task automatic test_reset_abort();
    int n_done;
    set_req(3'd1, 3'd3, 3'd0, 16'h1234, 16'h0, 16'd500, 1'b0);
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (bus0.busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%0b exp=0", bus0.busy); end
    n_done = 0;
    repeat (2) begin @(negedge clk); if (bus0.done) n_done++; end
    rst_n = 1'b1;
    repeat (4) begin @(negedge clk); if (bus0.done) n_done++; end
    checks++; if (n_done !== 0) begin failures++; $display("FAIL abort_done got=%0d exp=0", n_done); end
    do_txn(1'b0, 3'd0, 3'd3, 3'd0, 16'h1234, 16'h0, 16'd0, 1'b0);
    checks++; if (r_bal !== 16'd1000) begin failures++; $display("FAIL abort_acc3 got=%0d exp=1000", r_bal); end
    do_txn(1'b0, 3'd0, 3'd1, 3'd0, 16'h1234, 16'h0, 16'd0, 1'b0);
    checks++; if (r_bal !== 16'd1000) begin failures++; $display("FAIL abort_acc1 got=%0d exp=1000", r_bal); end
    do_txn(1'b0, 3'd0, 3'd4, 3'd0, 16'h1234, 16'h0, 16'd0, 1'b0);
    checks++; if (r_err !== 3'd0) begin failures++; $display("FAIL unlock_acc4 got=%0d exp=0", r_err); end
    do_txn(1'b0, 3'd0, 3'd7, 3'd0, 16'h1234, 16'h0, 16'd0, 1'b0);
    checks++; if (r_err !== 3'd0) begin failures++; $display("FAIL pin_restored got=%0d exp=0", r_err); end
  endtask

  task automatic test_dst_range();
    do_txn(1'b1, 3'd4, 3'd0, 3'd7, 16'h1234, 16'h0, 16'd10, 1'b0);
    checks++; if (r_err !== 3'd1 || r_bal !== 16'd1000) begin failures++; $display("FAIL n6_dst7 got=%0d/%0d exp=1/1000", r_err, r_bal); end
    do_txn(1'b1, 3'd0, 3'd6, 3'd0, 16'h1234, 16'h0, 16'd0, 1'b0);
    checks++; if (r_err !== 3'd1 || r_bal !== 16'd0 || r_success !== 1'b0) begin failures++;
      $display("FAIL n6_acc6 got=%0d/%0d/%0b exp=1/0/0", r_err, r_bal, r_success); end
    do_txn(1'b1, 3'd4, 3'd0, 3'd5, 16'h1234, 16'h0, 16'd100, 1'b0);
    checks++; if (r_err !== 3'd0 || r_bal !== 16'd900) begin failures++; $display("FAIL n6_xfr_to5 got=%0d/%0d exp=0/900", r_err, r_bal); end
    do_txn(1'b1, 3'd0, 3'd5, 3'd0, 16'h1234, 16'h0, 16'd0, 1'b0);
    checks++; if (r_bal !== 16'd1100) begin failures++; $display("FAIL n6_acc5 got=%0d exp=1100", r_bal); end
  endtask

  initial begin
    test_reset();
    test_inquiry();
    test_withdraw();
    test_deposit();
    test_lockout();
    test_transfer();
    test_illegal_op();
    test_pin_change();
    test_back_to_back();
    test_busy_ignore();
    test_reset_abort();
    test_dst_range();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
